calc_program_engine: RTL
========================

// Module: calc_program_engine
// PURPOSE
//  Parametrised program-buffered calculator. Loads up to DEPTH instruction words over a
//  valid/ready stream, executes them in order on start, and streams one result per instruction.
//  Adds load/result backpressure, run/done control and program replay.
//  Sits between the instruction source (host/switch loader) and the display/result consumer.
// PARAMETERS
//  OPND_W   8   operand width; instruction word = {op[1:0], A[OPND_W-1:0], B[OPND_W-1:0]}
//  DEPTH    16  instruction slots (power of 2, >=2); CNT_W = $clog2(DEPTH)+1
//  RES_W    derived = 2*OPND_W, result width (not overridable)
// PORTS
//  clk        in   1            clock
//  reset      in   1            asynchronous, active-high
//  in_valid   in   1            instruction word offered
//  in_ready   out  1            LOAD state and count < DEPTH
//  in_data    in   2*OPND_W+2   instruction word
//  start      in   1            begin execution (sampled in LOAD only)
//  keep_prog  in   1            sampled with start: 1 = keep program after run (replay)
//  clear      in   1            synchronous flush/abort
//  count      out  CNT_W        instructions currently stored
//  busy       out  1            state != LOAD
//  out_valid  out  1            result word valid
//  out_ready  in   1            consumer accepts result
//  out_result out  RES_W        unsigned result magnitude
//  out_neg    out  1            result sign (SUB only)
//  out_idx    out  CNT_W-1      slot index of the instruction producing this result
//  done       out  1            one-cycle pulse after last result accepted
// BEHAVIOUR
//  Reset: state=LOAD, count=0, rd_ptr=0, out_valid=0, out_result=0, out_neg=0, out_idx=0,
//   done=0, keep flag=0; memory contents not reset. Reset mid-run aborts with no done.
//  Ops: 00 ADD A+B zero-ext; 01 SUB |A-B|, neg=(A<B), A==B -> 0, neg=0;
//   10 MUL A*B (full RES_W, no overflow); 11 AND A&B zero-ext. out_neg=0 for non-SUB.
//  FSM LOAD: in_valid&&in_ready writes mem[count], count++. count==DEPTH -> in_ready=0, extra
//   words not accepted (held by source). start with count>0 -> RUN, rd_ptr=0, latch keep_prog;
//   start with count==0 ignored. start and accepted write same cycle: write lands, start uses
//   new count.
//  FSM RUN: output register loads when !out_valid || out_ready; load takes mem[rd_ptr],
//   computes ALU, sets out_valid, out_idx=rd_ptr, rd_ptr++. After issuing slot count-1 -> DRAIN.
//   Latency: start at cycle T -> first out_valid at T+2; full throughput 1 result/cycle with
//   out_ready=1. out_valid/out_result/out_neg/out_idx stable while out_valid && !out_ready.
//  FSM DRAIN: wait for last result accepted (out_valid&&out_ready) -> pulse done next cycle,
//   go to LOAD; count cleared unless keep flag set (then same program replays on next start).
//  in_ready=0 and start ignored in RUN/DRAIN. clear: LOAD -> count=0; RUN/DRAIN -> out_valid=0,
//   rd_ptr=0, count=0, back to LOAD, no done. clear beats start and in_valid in same cycle.
// STRUCTURE
//  Package calc_pkg: op enum (OP_ADD, OP_SUB, OP_MUL, OP_AND), state enum (S_LOAD, S_RUN,
//   S_DRAIN), instruction field offset functions of OPND_W.
//  Sub-module calc_alu #(OPND_W): purely combinational op/A/B -> result/neg, instantiated once.
//  Memory: DEPTH x (2*OPND_W+2) register array, one write port, one read port.
// TESTING
//  Load {00,3,5},{01,2,9},{10,200,200},{11,F0,3C}, start, out_ready=1 -> results 8/0, 7/1,
//   40000/0, 0x30/0, out_idx 0..3, done pulse 1 cycle after last accept, count->0.
//  Fill DEPTH=16 words with in_valid held high -> in_ready low after 16th; 17th not accepted.
//  out_ready toggled randomly during run -> every result delivered once, in order, stable
//   while stalled; out_valid first at start+2.
//  keep_prog=1 run, then second start -> identical result stream, no reload needed.
//  clear asserted mid-RUN after 2 results -> out_valid=0 next cycle, no done, count=0, in_ready=1.
//  start with count==0 and reset asserted mid-RUN -> no state change / all outputs to reset values.

Source files
------------

// File: rtl/calc_program_engine_pkg.sv
// calc_pkg: shared types and instruction-field layout helpers for the
// program-buffered calculator.
package calc_pkg;

    // ALU operation encoding carried in the top two bits of each instruction.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_AND = 2'b11
    } op_e;

    // Engine control states.
    typedef enum logic [1:0] {
        S_LOAD  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10
    } state_e;

    // Instruction word = {op[1:0], A[opnd_w-1:0], B[opnd_w-1:0]}; B sits at bit 0.
    function automatic int word_w(input int opnd_w);
        return 2 * opnd_w + 2;
    endfunction

    function automatic int op_lsb(input int opnd_w);
        return 2 * opnd_w;
    endfunction

    function automatic int a_lsb(input int opnd_w);
        return opnd_w;
    endfunction

endpackage

// File: rtl/calc_program_engine_if.sv
// Instruction-load and result streams of the calculator engine.
// master = instruction source / result consumer, slave = engine.
interface calc_program_engine_if #(
    parameter int OPND_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int RES_W  = 2 * OPND_W;
    localparam int WORD_W = 2 * OPND_W + 2;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [RES_W-1:0]  out_result;
    logic              out_neg;
    logic [CNT_W-2:0]  out_idx;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_result, out_neg, out_idx
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_result, out_neg, out_idx
    );

endinterface

// File: rtl/calc_program_engine_alu.sv
// calc_alu: combinational op/A/B -> unsigned magnitude plus sign.
// Only SUB can produce a negative sign; A==B gives 0 with positive sign.
module calc_alu
    import calc_pkg::*;
#(
    parameter int OPND_W = 8
) (
    input  op_e                 op_i,
    input  logic [OPND_W-1:0]   a_i,
    input  logic [OPND_W-1:0]   b_i,
    output logic [2*OPND_W-1:0] result_o,
    output logic                neg_o
);
    localparam logic [OPND_W-1:0] ZEXT = '0;

    // Evaluate the selected operation on the current instruction operands.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        result_o = '0;
        neg_o    = 1'b0;
        case (op_i)
            OP_ADD: result_o = {ZEXT, a_i} + {ZEXT, b_i};
            OP_SUB: begin
                if (a_i < b_i) begin
                    result_o = {ZEXT, b_i - a_i};
                    neg_o    = 1'b1;
                end else begin
                    result_o = {ZEXT, a_i - b_i};
                end
            end
            OP_MUL: result_o = {ZEXT, a_i} * {ZEXT, b_i};
            OP_AND: result_o = {ZEXT, a_i & b_i};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/calc_program_engine.sv
// calc_program_engine: buffers up to DEPTH instructions, runs them in order on
// start and streams one registered result per instruction with backpressure.
// A kept program can be replayed by a later start without reloading.
module calc_program_engine
    import calc_pkg::*;
#(
    parameter int  OPND_W = 8,
    parameter int  DEPTH  = 16,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    calc_program_engine_if.slave bus,
    input  logic               start,
    input  logic               keep_prog,
    input  logic               clear,
    output logic [CNT_W-1:0]   count,
    output logic               busy,
    output logic               done
);
    localparam int RES_W  = 2 * OPND_W;
    localparam int WORD_W = word_w(OPND_W);
    localparam int IDX_W  = CNT_W - 1;
    localparam int OP_LSB = op_lsb(OPND_W);
    localparam int A_LSB  = a_lsb(OPND_W);

    state_e            state_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  rd_ptr_q;
    logic              keep_q;
    logic              out_valid_q;
    logic [RES_W-1:0]  out_result_q;
    logic              out_neg_q;
    logic [IDX_W-1:0]  out_idx_q;
    logic              done_q;
    logic [WORD_W-1:0] mem_q [DEPTH];

    logic              in_fire;
    logic              out_load;
    logic [CNT_W-1:0]  count_d;
    logic [WORD_W-1:0] rd_word;
    logic [RES_W-1:0]  alu_res;
    logic              alu_neg;

    // A clear in the same cycle overrides an offered word: it is dropped.
    assign bus.in_ready = (state_q == S_LOAD) && (count_q < CNT_W'(DEPTH));
    assign in_fire      = bus.in_valid && bus.in_ready && !clear;
    assign count_d      = count_q + CNT_W'(in_fire);
    assign out_load     = !out_valid_q || bus.out_ready;
    assign rd_word      = mem_q[rd_ptr_q[IDX_W-1:0]];

    calc_alu #(.OPND_W(OPND_W)) u_alu (
        .op_i     (op_e'(rd_word[OP_LSB +: 2])),
        .a_i      (rd_word[A_LSB +: OPND_W]),
        .b_i      (rd_word[OPND_W-1:0]),
        .result_o (alu_res),
        .neg_o    (alu_neg)
    );

    // Program store: one write port fed by the load stream.
    // NOTE: storage is deliberately not reset; count_q alone marks valid slots.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_q[count_q[IDX_W-1:0]] <= bus.in_data;
        end
    end

    // Control FSM with registered result stage and done pulse.
    // NOTE: all state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_LOAD;
            count_q      <= '0;
            rd_ptr_q     <= '0;
            keep_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_neg_q    <= 1'b0;
            out_idx_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear) begin
                state_q     <= S_LOAD;
                count_q     <= '0;
                rd_ptr_q    <= '0;
                keep_q      <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        count_q <= count_d;
                        if (start && (count_d != '0)) begin
                            state_q  <= S_RUN;
                            rd_ptr_q <= '0;
                            keep_q   <= keep_prog;
                        end
                    end
                    S_RUN: begin
                        if (out_load) begin
                            out_valid_q  <= 1'b1;
                            out_result_q <= alu_res;
                            out_neg_q    <= alu_neg;
                            out_idx_q    <= rd_ptr_q[IDX_W-1:0];
                            rd_ptr_q     <= rd_ptr_q + CNT_W'(1);
                            if (rd_ptr_q == count_q - CNT_W'(1)) begin
                                state_q <= S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (out_valid_q && bus.out_ready) begin
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            state_q     <= S_LOAD;
                            rd_ptr_q    <= '0;
                            if (!keep_q) begin
                                count_q <= '0;
                            end
                        end
                    end
                    default: state_q <= S_LOAD;
                endcase
            end
        end
    end

    assign count          = count_q;
    assign busy           = (state_q != S_LOAD);
    assign done           = done_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_neg    = out_neg_q;
    assign bus.out_idx    = out_idx_q;

endmodule
